// File: rtl/transmissor_relatorio_pkg.sv
// Shared definitions for the grade-report transmitter: the byte FSM states,
// the field identifiers that tag every packet byte and the packet builder.
package transmissor_relatorio_pkg;

  typedef enum logic [1:0] {
    OCIOSO,
    INICIO,
    DADOS,
    PARADA
  } estado_t;

  localparam logic [3:0] ID_CABECALHO    = 4'hA;
  localparam logic [3:0] ID_TEMPERATURA  = 4'h1;
  localparam logic [3:0] ID_PH           = 4'h2;
  localparam logic [3:0] ID_LUMINOSIDADE = 4'h3;
  localparam logic [3:0] ID_UMIDADE      = 4'h4;
  localparam logic [3:0] ID_MEDIA        = 4'h5;

  localparam int NUM_BYTES = 7;

  // Returns packet byte 'idx' built from a capture word laid out as
  // {tipo_planta, temperatura, pH, luminosidade, umidade, media}.
  // Index 6 (and anything above) is the XOR checksum of bytes 0..5.
  function automatic logic [7:0] byte_pacote(input logic [23:0] cap,
                                             input logic [2:0]  idx);
    logic [7:0] b0, b1, b2, b3, b4, b5;
    logic [7:0] res;
    b0 = {ID_CABECALHO,    cap[23:20]};
    b1 = {ID_TEMPERATURA,  cap[19:16]};
    b2 = {ID_PH,           cap[15:12]};
    b3 = {ID_LUMINOSIDADE, cap[11:8]};
    b4 = {ID_UMIDADE,      cap[7:4]};
    b5 = {ID_MEDIA,        cap[3:0]};
    case (idx)
      3'd0:    res = b0;
      3'd1:    res = b1;
      3'd2:    res = b2;
      3'd3:    res = b3;
      3'd4:    res = b4;
      3'd5:    res = b5;
      default: res = b0 ^ b1 ^ b2 ^ b3 ^ b4 ^ b5;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/transmissor_relatorio_if.sv
// Bundle of the report transmitter's data/handshake signals.
//   iniciar, tipo_planta, nota_* , media : driven by the producer (master)
//   tx, ocupado, pronto                  : driven by the transmitter (slave)
interface transmissor_relatorio_if;
  logic       iniciar;
  logic [3:0] tipo_planta;
  logic [3:0] nota_temperatura;
  logic [3:0] nota_pH;
  logic [3:0] nota_luminosidade;
  logic [3:0] nota_umidade;
  logic [3:0] media;
  logic       tx;
  logic       ocupado;
  logic       pronto;

  modport master (
    output iniciar, tipo_planta, nota_temperatura, nota_pH,
           nota_luminosidade, nota_umidade, media,
    input  tx, ocupado, pronto
  );

  modport slave (
    input  iniciar, tipo_planta, nota_temperatura, nota_pH,
           nota_luminosidade, nota_umidade, media,
    output tx, ocupado, pronto
  );
endinterface

// File: rtl/transmissor_relatorio_serializador_uart.sv
// Single-byte 8N1 UART shifter, LSB first.
//   clock, reset (async, active low)
//   i_byte     : byte to send, taken when i_carregar is high while o_livre
//   i_carregar : load request
//   o_tx       : registered serial line, idles high
//   o_livre    : high when a load will be accepted on the next edge (idle,
//                or the final cycle of the stop bit, which chains frames
//                without any idle bit in between)
module serializador_uart
  import transmissor_relatorio_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] i_byte,
  input  logic       i_carregar,
  output logic       o_tx,
  output logic       o_livre
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

  estado_t       r_estado;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [7:0]    r_dados;
  logic          r_tx;

  logic w_fim_bit;
  assign w_fim_bit = (r_baud == BAUD_MAX);
  assign o_livre   = (r_estado == OCIOSO) || ((r_estado == PARADA) && w_fim_bit);
  assign o_tx      = r_tx;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado <= OCIOSO;
      r_baud   <= '0;
      r_bit    <= '0;
      r_dados  <= '0;
      r_tx     <= 1'b1;
    end else begin
      case (r_estado)
        OCIOSO: begin
          r_tx   <= 1'b1;
          r_baud <= '0;
          r_bit  <= '0;
          if (i_carregar) begin
            r_dados  <= i_byte;
            r_tx     <= 1'b0;
            r_estado <= INICIO;
          end
        end
        INICIO: begin
          if (w_fim_bit) begin
            r_baud   <= '0;
            r_bit    <= '0;
            r_tx     <= r_dados[0];
            r_estado <= DADOS;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        DADOS: begin
          if (w_fim_bit) begin
            r_baud <= '0;
            if (r_bit == 3'd7) begin
              r_bit    <= '0;
              r_tx     <= 1'b1;
              r_estado <= PARADA;
            end else begin
              // Shift so the next bit to send is always at position 1.
              r_bit   <= r_bit + 1'b1;
              r_dados <= {1'b0, r_dados[7:1]};
              r_tx    <= r_dados[1];
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        PARADA: begin
          if (w_fim_bit) begin
            r_baud <= '0;
            if (i_carregar) begin
              r_dados  <= i_byte;
              r_tx     <= 1'b0;
              r_estado <= INICIO;
            end else begin
              r_estado <= OCIOSO;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: r_estado <= OCIOSO;
      endcase
    end
  end

endmodule

// File: rtl/transmissor_relatorio.sv
// Grade-report transmitter. On iniciar (while idle) captures the plant type,
// four grades and the average, then sends the 7-byte packet
// A/tipo, 1/temp, 2/pH, 3/lum, 4/umid, 5/media, checksum over one UART line.
//   clock, reset (async, active low)
//   bus (slave) : iniciar + input fields in; tx, ocupado, pronto out
module transmissor_relatorio
  import transmissor_relatorio_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                 clock,
  input  logic                 reset,
  transmissor_relatorio_if.slave bus
);

  logic [23:0] r_captura;
  logic [2:0]  r_byte;
  logic        r_ocupado;
  logic        r_pronto;

  logic [23:0] w_entrada;
  logic        w_aceitar;
  logic        w_proximo;
  logic        w_fim_pacote;
  logic        w_carregar;
  logic [7:0]  w_byte;
  logic        w_livre;
  logic        w_tx;

  assign w_entrada = {bus.tipo_planta, bus.nota_temperatura, bus.nota_pH,
                      bus.nota_luminosidade, bus.nota_umidade, bus.media};

  assign w_aceitar    = bus.iniciar && !r_ocupado;
  assign w_proximo    = r_ocupado && w_livre && (r_byte != 3'(NUM_BYTES - 1));
  assign w_fim_pacote = r_ocupado && w_livre && (r_byte == 3'(NUM_BYTES - 1));
  assign w_carregar   = w_aceitar || w_proximo;

  // The first byte is loaded on the same edge the inputs are captured, so it
  // comes straight from the inputs; later bytes come from the capture register.
  assign w_byte = w_aceitar ? byte_pacote(w_entrada, 3'd0)
                            : byte_pacote(r_captura, r_byte + 3'd1);

  serializador_uart #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_serializador (
    .clock     (clock),
    .reset     (reset),
    .i_byte    (w_byte),
    .i_carregar(w_carregar),
    .o_tx      (w_tx),
    .o_livre   (w_livre)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_captura <= '0;
      r_byte    <= '0;
      r_ocupado <= 1'b0;
      r_pronto  <= 1'b0;
    end else begin
      r_pronto <= 1'b0;
      if (w_aceitar) begin
        r_captura <= w_entrada;
        r_byte    <= '0;
        r_ocupado <= 1'b1;
      end else if (w_proximo) begin
        r_byte <= r_byte + 3'd1;
      end else if (w_fim_pacote) begin
        r_byte    <= '0;
        r_ocupado <= 1'b0;
        r_pronto  <= 1'b1;
      end
    end
  end

  assign bus.tx      = w_tx;
  assign bus.ocupado = r_ocupado;
  assign bus.pronto  = r_pronto;

endmodule
